// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: datapath widths, opcode field bounds, reset PC.
package pipeline_pkg;

    localparam int unsigned ADDR_W     = 20;
    localparam int unsigned INSTR_W    = 20;
    localparam int unsigned OPCODE_MSB = 19;
    localparam int unsigned OPCODE_LSB = 16;
    localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    // Fetch control state, encoded directly as {reqValid, skidValid}.
    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_WAIT = 2'b10,
        FS_HELD = 2'b01
    } fetchState_e;

    // Extract the opcode field from a full instruction word.
    function automatic logic [OPCODE_W-1:0] opcodeOf(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction/PC pair returned while decode stalls.
import pipeline_pkg::*;

module fetch_skid_buffer #(
    parameter int unsigned ADDR_W  = pipeline_pkg::ADDR_W,
    parameter int unsigned INSTR_W = pipeline_pkg::INSTR_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instrIn,
    input  logic [ADDR_W-1:0]  pcIn,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    // Clear wins over load so a redirect always empties the entry.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instrIn;
            pc    <= pcIn;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, tracks one in-flight memory read, absorbs
// decode stalls through a skid entry and squashes wrong-path fetches on jumps.
import pipeline_pkg::*;

module fetch_stage #(
    parameter int unsigned       ADDR_W   = pipeline_pkg::ADDR_W,
    parameter int unsigned       INSTR_W  = pipeline_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(pipeline_pkg::RESET_PC)
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [3:0]         if_id_opcode,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid
);

    logic [ADDR_W-1:0]  pc, pcNext;
    logic               reqValid, reqValidNext;
    logic [ADDR_W-1:0]  reqPc, reqPcNext;
    logic               skidValid, skidLoad, skidClear;
    logic [INSTR_W-1:0] skidInstr;
    logic [ADDR_W-1:0]  skidPc;
    logic               ifIdValidNext;
    logic [INSTR_W-1:0] ifIdInstrNext;
    logic [ADDR_W-1:0]  ifIdPcNext;
    fetchState_e        state;

    assign state        = fetchState_e'({reqValid, skidValid});
    assign imem_addr    = jump_en ? jump_addr : pc;
    assign if_id_opcode = opcodeOf(if_id_instr);

    fetch_skid_buffer #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) uSkid (
        .Clock  (Clock),
        .Reset  (Reset),
        .load   (skidLoad),
        .clear  (skidClear),
        .instrIn(imem_data),
        .pcIn   (reqPc),
        .valid  (skidValid),
        .instr  (skidInstr),
        .pc     (skidPc)
    );

    // Next-state: jump beats stall beats run; the returning word is only
    // consumed when a request is live and not being redirected away.
    always_comb begin
        pcNext        = pc;
        reqValidNext  = 1'b0;
        reqPcNext     = reqPc;
        skidLoad      = 1'b0;
        skidClear     = 1'b0;
        ifIdValidNext = if_id_valid;
        ifIdInstrNext = if_id_instr;
        ifIdPcNext    = if_id_pc;
        if (jump_en) begin
            reqValidNext  = 1'b1;
            reqPcNext     = jump_addr;
            pcNext        = jump_addr + ADDR_W'(1);
            skidClear     = 1'b1;
            ifIdValidNext = 1'b0;
        end else if (stall) begin
            skidLoad = (state == FS_WAIT);
        end else begin
            case (state)
                FS_HELD: begin
                    ifIdValidNext = 1'b1;
                    ifIdInstrNext = skidInstr;
                    ifIdPcNext    = skidPc;
                    skidClear     = 1'b1;
                end
                FS_WAIT: begin
                    ifIdValidNext = 1'b1;
                    ifIdInstrNext = imem_data;
                    ifIdPcNext    = reqPc;
                end
                default: ifIdValidNext = 1'b0;
            endcase
            reqValidNext = 1'b1;
            reqPcNext    = pc;
            pcNext       = pc + ADDR_W'(1);
        end
    end

    // PC, request tracking and IF/ID registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc          <= RESET_PC;
            reqValid    <= 1'b0;
            reqPc       <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
        end else begin
            pc          <= pcNext;
            reqValid    <= reqValidNext;
            reqPc       <= reqPcNext;
            if_id_valid <= ifIdValidNext;
            if_id_instr <= ifIdInstrNext;
            if_id_pc    <= ifIdPcNext;
        end
    end

    // A live request and a held word must never coexist.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            assert (!(reqValid && skidValid));
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a synchronous memory returning 0x10000 | addr.
module tb_fetch_stage;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [19:0] imem_addr;
    logic [19:0] imem_data = '0;
    logic        stall;
    logic        jump_en;
    logic [19:0] jump_addr;
    logic [19:0] if_id_instr;
    logic [3:0]  if_id_opcode;
    logic [19:0] if_id_pc;
    logic        if_id_valid;

    int vectors     = 0;
    int miscompares = 0;

    fetch_stage dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .if_id_instr (if_id_instr),
        .if_id_opcode(if_id_opcode),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid)
    );

    always #5 Clock = ~Clock;

    // Synchronous instruction memory: word for an address appears one edge later.
    always @(posedge Clock) imem_data <= 20'h10000 | imem_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Valid IF/ID slot carrying the word for address p.
    task automatic chkInstr(input string tag, input logic [19:0] p);
        logic [19:0] w;
        w = 20'h10000 | p;
        chk({tag, ".valid"}, 32'(if_id_valid), 32'd1);
        chk({tag, ".pc"}, 32'(if_id_pc), 32'(p));
        chk({tag, ".instr"}, 32'(if_id_instr), 32'(w));
        chk({tag, ".opcode"}, 32'(if_id_opcode), 32'(w[19:16]));
    endtask

    task automatic chkBubble(input string tag);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, ".opcode"}, 32'(if_id_opcode), 32'(if_id_instr[19:16]));
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = '0;
        step(); step();
        chk("rst.valid", 32'(if_id_valid), 32'd0);
        chk("rst.instr", 32'(if_id_instr), 32'd0);
        chk("rst.pc", 32'(if_id_pc), 32'd0);
        chk("rst.opcode", 32'(if_id_opcode), 32'd0);
        chk("rst.imem_addr", 32'(imem_addr), 32'd0);

        // Free run: first fetch issues on the first edge, word 0 on the second.
        Reset = 1'b0;
        step();
        chkBubble("run.e1");
        chk("run.e1.imem_addr", 32'(imem_addr), 32'd1);
        step(); chkInstr("run.pc0", 20'h0);
        step(); chkInstr("run.pc1", 20'h1);
        step(); chkInstr("run.pc2", 20'h2);
        step(); chkInstr("run.pc3", 20'h3);
        step(); chkInstr("run.pc4", 20'h4);

        // Three-cycle stall with pc 5 in flight: it lands in the skid.
        stall = 1'b1;
        step(); chkInstr("stall.c1", 20'h4);
        step(); chkInstr("stall.c2", 20'h4);
        step(); chkInstr("stall.c3", 20'h4);
        stall = 1'b0;
        step(); chkInstr("release.pc5", 20'h5);
        step(); chkInstr("release.pc6", 20'h6);
        step(); chkInstr("release.pc7", 20'h7);

        // Jump while pc 8 is in flight.
        jump_en = 1'b1; jump_addr = 20'h00100;
        #1 chk("jump.imem_addr", 32'(imem_addr), 32'h100);
        step(); chkBubble("jump.bubble");
        jump_en = 1'b0;
        step(); chkInstr("jump.t0", 20'h00100);
        step(); chkInstr("jump.t1", 20'h00101);

        // Jump arriving while the skid holds a word and stall is still high.
        stall = 1'b1;
        step(); chkInstr("hs.hold1", 20'h00101);
        step(); chkInstr("hs.hold2", 20'h00101);
        jump_en = 1'b1; jump_addr = 20'h00200;
        step(); chkBubble("hs.jump");
        jump_en = 1'b0;
        step(); chkBubble("hs.stall1");
        step(); chkBubble("hs.stall2");
        stall = 1'b0;
        step(); chkInstr("hs.t0", 20'h00200);
        step(); chkInstr("hs.t1", 20'h00201);

        // PC wrap at the top of the address space.
        jump_en = 1'b1; jump_addr = 20'hFFFFF;
        step(); chkBubble("wrap.bubble");
        jump_en = 1'b0;
        step(); chkInstr("wrap.top", 20'hFFFFF);
        step(); chkInstr("wrap.zero", 20'h00000);

        // Reset asserted during a stall with the skid full.
        stall = 1'b1;
        step(); chkInstr("rs.hold", 20'h00000);
        Reset = 1'b1;
        step();
        chk("rs.valid", 32'(if_id_valid), 32'd0);
        chk("rs.instr", 32'(if_id_instr), 32'd0);
        chk("rs.pc", 32'(if_id_pc), 32'd0);
        chk("rs.opcode", 32'(if_id_opcode), 32'd0);
        chk("rs.imem_addr", 32'(imem_addr), 32'd0);
        Reset = 1'b0; stall = 1'b0;
        step(); chkBubble("rs.e1");
        step(); chkInstr("rs.pc0", 20'h0);
        step(); chkInstr("rs.pc1", 20'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
